axi_ad9364_dac_sched: RTL and testbench

- Transmit-side sample scheduler feeding the dac_* inputs of the AD9364 digital interface.
- Paces dac_valid to the interface's slot rate: 1 strobe per 2 clk in 1R1T mode, 1 per 4 clk in 2R2T mode.
- Selects between a DMA stream source and an internal alternating test pattern.
- Detects and counts DMA underflow.
- Sits between the DMA/pattern logic and the digital interface, in the interface's clk domain.

---
 rtl/axi_ad9364_dac_sched_pkg.sv | 43 ++++
 rtl/axi_ad9364_slot_timer.sv | 37 +++
 rtl/axi_ad9364_dac_sched.sv | 172 +++++++++++++++++
 tb/tb_axi_ad9364_dac_sched.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_ad9364_dac_sched_pkg.sv
// ==== axi_ad9364_dac_sched_pkg : shared types/constants for the AD9364 DAC scheduler ====
// ==== rev 1.0 ====
`default_nettype none

package axi_ad9364_dac_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_STOP = 2'd3
  } sched_state_t;

  localparam int PERIOD_R1 = 2;
  localparam int PERIOD_R2 = 4;

  typedef struct packed {
    logic [11:0] i1;
    logic [11:0] q1;
    logic [11:0] i2;
    logic [11:0] q2;
  } dac_sample_t;

  localparam logic [11:0] PAT_I1_A_DEF = 12'o2064;
  localparam logic [11:0] PAT_Q1_A_DEF = 12'o1753;
  localparam logic [11:0] PAT_I1_B_DEF = 12'o4402;
  localparam logic [11:0] PAT_Q1_B_DEF = 12'o1337;
  localparam logic [11:0] PAT_CH2_DEF  = 12'o0000;

  // 1R1T carries no second channel, so its lanes are blanked before leaving the block
  function automatic dac_sample_t mask_r1(input dac_sample_t s, input logic r1);
    dac_sample_t m;
    m = s;
    if (r1) begin
      m.i2 = '0;
      m.q2 = '0;
    end
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axi_ad9364_slot_timer.sv
// ==== axi_ad9364_slot_timer : slot counter and strobe for the DAC scheduler ====
// ==== rev 1.0 ====
`default_nettype none

module axi_ad9364_slot_timer
  import axi_ad9364_dac_sched_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic active,
  input  logic gate,
  input  logic r1_mode,
  output logic strobe,
  output logic wrap
);

  logic [1:0] slot_cnt;
  logic [1:0] last_slot;

  assign last_slot = r1_mode ? 2'(PERIOD_R1 - 1) : 2'(PERIOD_R2 - 1);
  assign wrap      = active && (slot_cnt == last_slot);
  assign strobe    = gate && (slot_cnt == 2'd0);

  // Held at zero while inactive so every run starts on a strobe slot
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      slot_cnt <= 2'd0;
    end else if (!active || wrap) begin
      slot_cnt <= 2'd0;
    end else begin
      slot_cnt <= slot_cnt + 2'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/axi_ad9364_dac_sched.sv
// ==== axi_ad9364_dac_sched : AD9364 TX slot scheduler, DMA/pattern source, underflow count ====
// ==== rev 1.0 ; option macro AD9364_DAC_HOLD_LAST_EN repeats last DMA sample on underflow ====
`default_nettype none

module axi_ad9364_dac_sched
  import axi_ad9364_dac_sched_pkg::*;
#(
  parameter logic [11:0] PAT_I1_A    = PAT_I1_A_DEF,
  parameter logic [11:0] PAT_Q1_A    = PAT_Q1_A_DEF,
  parameter logic [11:0] PAT_I1_B    = PAT_I1_B_DEF,
  parameter logic [11:0] PAT_Q1_B    = PAT_Q1_B_DEF,
  parameter logic [11:0] PAT_I2_A    = PAT_CH2_DEF,
  parameter logic [11:0] PAT_Q2_A    = PAT_CH2_DEF,
  parameter logic [11:0] PAT_I2_B    = PAT_CH2_DEF,
  parameter logic [11:0] PAT_Q2_B    = PAT_CH2_DEF,
  parameter int          UFLOW_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   enable,
  input  logic                   r1_mode,
  input  logic                   src_sel,
  input  logic                   dma_valid,
  output logic                   dma_ready,
  input  logic [11:0]            dma_data_i1,
  input  logic [11:0]            dma_data_q1,
  input  logic [11:0]            dma_data_i2,
  input  logic [11:0]            dma_data_q2,
  output logic                   dac_valid,
  output logic [11:0]            dac_data_i1,
  output logic [11:0]            dac_data_q1,
  output logic [11:0]            dac_data_i2,
  output logic [11:0]            dac_data_q2,
  output logic                   dac_r1_mode,
  output logic                   busy,
  output logic                   underflow,
  output logic [UFLOW_CNT_W-1:0] underflow_cnt,
  input  logic                   underflow_clr
);

  localparam dac_sample_t PAT_A = '{i1: PAT_I1_A, q1: PAT_Q1_A, i2: PAT_I2_A, q2: PAT_Q2_A};
  localparam dac_sample_t PAT_B = '{i1: PAT_I1_B, q1: PAT_Q1_B, i2: PAT_I2_B, q2: PAT_Q2_B};

  sched_state_t state;
  logic         mode_r1;
  logic         src_pat;
  logic         toggle;
  dac_sample_t  out_s;
  dac_sample_t  dma_sample;
  dac_sample_t  uflow_sample;
  logic         strobe;
  logic         wrap;
  logic         slot_active;
  logic         transfer;
  logic         uflow_evt;
  logic         start;

  assign dma_sample  = '{i1: dma_data_i1, q1: dma_data_q1, i2: dma_data_i2, q2: dma_data_q2};
  assign slot_active = (state == ST_RUN) || (state == ST_STOP);
  assign start       = (state == ST_IDLE) && enable;

  axi_ad9364_slot_timer u_slot_timer (
    .clk     (clk),
    .rstn    (rstn),
    .active  (slot_active),
    .gate    (state == ST_RUN),
    .r1_mode (mode_r1),
    .strobe  (strobe),
    .wrap    (wrap)
  );

  assign dma_ready = strobe && !src_pat;
  assign transfer  = dma_ready && dma_valid;
  assign uflow_evt = dma_ready && !dma_valid;

`ifdef AD9364_DAC_HOLD_LAST_EN
  dac_sample_t last_good;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_good <= '0;
    end else if (start) begin
      last_good <= '0;
    end else if (transfer) begin
      last_good <= mask_r1(dma_sample, mode_r1);
    end
  end

  assign uflow_sample = last_good;
`else
  assign uflow_sample = '0;
`endif

  assign dac_data_i1 = out_s.i1;
  assign dac_data_q1 = out_s.q1;
  assign dac_data_i2 = out_s.i2;
  assign dac_data_q2 = out_s.q2;
  assign dac_r1_mode = mode_r1;
  assign busy        = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= ST_IDLE;
      mode_r1       <= 1'b0;
      src_pat       <= 1'b0;
      toggle        <= 1'b0;
      out_s         <= '0;
      dac_valid     <= 1'b0;
      underflow     <= 1'b0;
      underflow_cnt <= '0;
    end else begin
      dac_valid <= strobe;
      underflow <= uflow_evt;

      // A clear that collides with a new underflow keeps that underflow
      if (underflow_clr) begin
        underflow_cnt <= uflow_evt ? UFLOW_CNT_W'(1) : '0;
      end else if (uflow_evt && (underflow_cnt != '1)) begin
        underflow_cnt <= underflow_cnt + UFLOW_CNT_W'(1);
      end

      if (strobe) begin
        if (src_pat) begin
          out_s  <= mask_r1(toggle ? PAT_B : PAT_A, mode_r1);
          toggle <= ~toggle;
        end else if (dma_valid) begin
          out_s <= mask_r1(dma_sample, mode_r1);
        end else begin
          out_s <= uflow_sample;
        end
      end

      case (state)
        ST_IDLE: begin
          if (enable) begin
            mode_r1 <= r1_mode;
            src_pat <= src_sel;
            toggle  <= 1'b0;
            state   <= src_sel ? ST_RUN : ST_ARM;
          end
        end
        ST_ARM: begin
          if (!enable) begin
            state <= ST_IDLE;
          end else if (dma_valid) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!enable) begin
            if (wrap) begin
              state <= ST_IDLE;
              out_s <= '0;
            end else begin
              state <= ST_STOP;
            end
          end
        end
        ST_STOP: begin
          if (wrap) begin
            state <= ST_IDLE;
            out_s <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axi_ad9364_dac_sched.sv
// ==== tb_axi_ad9364_dac_sched : directed self-checking bench for axi_ad9364_dac_sched ====
// ==== rev 1.0 ====
`default_nettype none

module tb_axi_ad9364_dac_sched;

  logic        clk = 1'b0;
  logic        rstn;
  logic        enable;
  logic        r1_mode;
  logic        src_sel;
  logic        dma_valid;
  logic        dma_ready;
  logic [11:0] dma_data_i1, dma_data_q1, dma_data_i2, dma_data_q2;
  logic        dac_valid;
  logic [11:0] dac_data_i1, dac_data_q1, dac_data_i2, dac_data_q2;
  logic        dac_r1_mode;
  logic        busy;
  logic        underflow;
  logic [15:0] underflow_cnt;
  logic        underflow_clr;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          vq[$];
  int          rq[$];
  logic [47:0] dq[$];
  logic [47:0] ufd[$];
  int          uf_n = 0;
  int          uf_orphan = 0;
  int          k;
  int          k0;
  logic        hs;
  logic        got;
  logic [47:0] exp_uf;

  localparam logic [47:0] PAT_A = {12'o2064, 12'o1753, 24'h0};
  localparam logic [47:0] PAT_B = {12'o4402, 12'o1337, 24'h0};

  always #5 clk = ~clk;

  axi_ad9364_dac_sched dut (
    .clk           (clk),
    .rstn          (rstn),
    .enable        (enable),
    .r1_mode       (r1_mode),
    .src_sel       (src_sel),
    .dma_valid     (dma_valid),
    .dma_ready     (dma_ready),
    .dma_data_i1   (dma_data_i1),
    .dma_data_q1   (dma_data_q1),
    .dma_data_i2   (dma_data_i2),
    .dma_data_q2   (dma_data_q2),
    .dac_valid     (dac_valid),
    .dac_data_i1   (dac_data_i1),
    .dac_data_q1   (dac_data_q1),
    .dac_data_i2   (dac_data_i2),
    .dac_data_q2   (dac_data_q2),
    .dac_r1_mode   (dac_r1_mode),
    .busy          (busy),
    .underflow     (underflow),
    .underflow_cnt (underflow_cnt),
    .underflow_clr (underflow_clr)
  );

  function automatic logic [47:0] samp(input int idx);
    logic [11:0] b;
    b = 12'(idx);
    return {12'h100 + b, 12'h200 + b, 12'h300 + b, 12'h400 + b};
  endfunction

  function automatic logic [47:0] r1m(input logic [47:0] s);
    return {s[47:24], 24'h0};
  endfunction

  function automatic logic [47:0] dac_now();
    return {dac_data_i1, dac_data_q1, dac_data_i2, dac_data_q2};
  endfunction

  task automatic check(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
    n_checks++;
    if (got_v !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got_v, exp_v);
    end
  endtask

  task automatic drive_sample(input int idx);
    {dma_data_i1, dma_data_q1, dma_data_i2, dma_data_q2} = samp(idx);
  endtask

  // One clock: sample handshake mid-cycle, advance the DMA sample after a consumed one
  task automatic tick();
    @(negedge clk);
    hs = dma_ready && dma_valid;
    @(posedge clk);
    #1;
    if (hs) begin
      k++;
      drive_sample(k);
    end
  endtask

  task automatic clear_log();
    vq.delete();
    rq.delete();
    dq.delete();
    ufd.delete();
    uf_n = 0;
    uf_orphan = 0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 20 && busy; i++) tick();
    check({tag, "_idle"}, busy, 1'b0);
    check({tag, "_data_clr"}, dac_now(), 48'h0);
  endtask

  task automatic wait_hs(input string tag);
    hs = 1'b0;
    for (int i = 0; i < 20 && !hs; i++) tick();
    check({tag, "_hs"}, hs, 1'b1);
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      cyc++;
      if (dac_valid) begin
        vq.push_back(cyc);
        dq.push_back(dac_now());
      end
      if (dma_ready && dma_valid) rq.push_back(cyc);
      if (underflow) begin
        uf_n++;
        ufd.push_back(dac_now());
        if (!dac_valid) uf_orphan++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    enable = 1'b0;
    r1_mode = 1'b0;
    src_sel = 1'b0;
    dma_valid = 1'b0;
    underflow_clr = 1'b0;
    k = 0;
    hs = 1'b0;
    drive_sample(0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", dac_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", dma_ready, 1'b0);
    check("rst_uflow", underflow, 1'b0);
    check("rst_cnt", underflow_cnt, 16'h0);
    check("rst_data", dac_now(), 48'h0);
    check("rst_mode", dac_r1_mode, 1'b0);
    rstn = 1'b1;
    tick();
    tick();

    // Pattern source, 1R1T
    src_sel = 1'b1;
    r1_mode = 1'b1;
    enable = 1'b1;
    clear_log();
    repeat (9) tick();
    check("t1_mode", dac_r1_mode, 1'b1);
    check("t1_nvalid", vq.size(), 4);
    for (int i = 1; i < vq.size(); i++) check("t1_gap", vq[i] - vq[i-1], 2);
    for (int i = 0; i < dq.size(); i++) check("t1_data", dq[i], (i % 2 == 0) ? PAT_A : PAT_B);
    enable = 1'b0;
    wait_idle("t1");

    // DMA source, 2R2T, continuous valid
    src_sel = 1'b0;
    r1_mode = 1'b0;
    dma_valid = 1'b1;
    k0 = k;
    enable = 1'b1;
    clear_log();
    repeat (13) tick();
    check("t2_mode", dac_r1_mode, 1'b0);
    check("t2_nready", rq.size(), 3);
    check("t2_nvalid", vq.size(), 3);
    for (int i = 0; i < vq.size() && i < rq.size(); i++) check("t2_lat", vq[i] - rq[i], 1);
    for (int i = 1; i < vq.size(); i++) check("t2_gap", vq[i] - vq[i-1], 4);
    for (int i = 0; i < dq.size(); i++) check("t2_data", dq[i], samp(k0 + i));
    enable = 1'b0;
    wait_idle("t2");

    // Underflow in DMA 1R1T
    src_sel = 1'b0;
    r1_mode = 1'b1;
    dma_valid = 1'b1;
    k0 = k;
    enable = 1'b1;
    clear_log();
    wait_hs("t3a");
    dma_valid = 1'b0;
    repeat (6) tick();
    dma_valid = 1'b1;
    tick();
`ifdef AD9364_DAC_HOLD_LAST_EN
    exp_uf = r1m(samp(k - 1));
`else
    exp_uf = 48'h0;
`endif
    check("t3_npulse", uf_n, 3);
    check("t3_cnt", underflow_cnt, 16'd3);
    check("t3_orphan", uf_orphan, 0);
    if (dq.size() > 0) check("t3_first", dq[0], r1m(samp(k0)));
    for (int i = 0; i < ufd.size(); i++) check("t3_ufdata", ufd[i], exp_uf);
    wait_hs("t3b");
    dma_valid = 1'b0;
    tick();
    underflow_clr = 1'b1;
    tick();
    underflow_clr = 1'b0;
`ifdef AD9364_DAC_HOLD_LAST_EN
    exp_uf = r1m(samp(k - 1));
`else
    exp_uf = 48'h0;
`endif
    check("t3_clr_pulse", underflow, 1'b1);
    check("t3_clr_cnt", underflow_cnt, 16'd1);
    check("t3_clr_data", dac_now(), exp_uf);
    dma_valid = 1'b1;
    enable = 1'b0;
    wait_idle("t3");

    // Mode lock and stop in 2R2T pattern mode
    src_sel = 1'b1;
    r1_mode = 1'b0;
    enable = 1'b1;
    tick();
    r1_mode = 1'b1;
    clear_log();
    repeat (12) tick();
    check("t4_mode", dac_r1_mode, 1'b0);
    check("t4_nvalid", vq.size(), 3);
    for (int i = 1; i < vq.size(); i++) check("t4_gap", vq[i] - vq[i-1], 4);
    if (dq.size() == 3) check("t4_data", dq[2], PAT_A);
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (dac_valid) begin
        got = 1'b1;
        break;
      end
    end
    check("t4_valid_seen", got, 1'b1);
    enable = 1'b0;
    r1_mode = 1'b0;
    @(posedge clk);
    #1;
    clear_log();
    check("t4_busy_stop1", busy, 1'b1);
    tick();
    check("t4_busy_stop2", busy, 1'b1);
    tick();
    check("t4_busy_idle", busy, 1'b0);
    check("t4_data_clr", dac_now(), 48'h0);
    repeat (5) tick();
    check("t4_no_valid", vq.size(), 0);

    // ARM wait without DMA data
    src_sel = 1'b0;
    r1_mode = 1'b0;
    dma_valid = 1'b0;
    enable = 1'b1;
    clear_log();
    repeat (10) tick();
    check("t5_arm_valid", vq.size(), 0);
    check("t5_arm_uflow", uf_n, 0);
    check("t5_arm_busy", busy, 1'b1);
    check("t5_arm_cnt", underflow_cnt, 16'd1);
    k0 = k;
    dma_valid = 1'b1;
    repeat (4) tick();
    check("t5_nready", rq.size(), 1);
    check("t5_nvalid", vq.size(), 1);
    if (vq.size() > 0 && rq.size() > 0) check("t5_lat", vq[0] - rq[0], 1);
    if (dq.size() > 0) check("t5_data", dq[0], samp(k0));

    // Asynchronous reset mid-run
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("t6_valid", dac_valid, 1'b0);
    check("t6_busy", busy, 1'b0);
    check("t6_ready", dma_ready, 1'b0);
    check("t6_data", dac_now(), 48'h0);
    check("t6_cnt", underflow_cnt, 16'h0);
    check("t6_uflow", underflow, 1'b0);
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    clear_log();
    repeat (3) tick();
    check("t6_idle", busy, 1'b0);
    check("t6_no_valid", vq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
